// File: rtl/adc_display_pkg.sv
// Shared types and helpers for the ADC millivolt display path.
package adc_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int         SCALE_MV  = 1000;
  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = BLANK_SEG;
    endcase
  endfunction

endpackage

// File: rtl/adc_display_bin2bcd_seq.sv
// Sequential double-dabble: 10-bit binary to three BCD digits, one bit per cycle.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [9:0]  sh;
  logic [3:0]  cnt;
  logic        busy;
  logic [11:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // done is a one-cycle pulse in the cycle after the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh   <= bin;
        bcd  <= '0;
        cnt  <= 4'd10;
        busy <= 1'b1;
      end else if (busy) begin
        {bcd, sh} <= {adj[10:0], sh, 1'b0};
        cnt       <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_display.sv
// Averages ADC samples, scales to millivolts, converts to BCD and scans a 4-digit display.
// state | meaning
// IDLE  | waiting for a completed sample batch
// MUL   | scale average to millivolts, start BCD conversion
// BCD   | double-dabble running (10 cycles)
// DONE  | mv_bcd updated, mv_valid asserted
module adc_display
  import adc_display_pkg::*;
#(
  parameter int SAMPLE_DIV  = 100000,
  parameter int AVG_LOG2    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_in,
  output logic [15:0] mv_bcd,
  output logic        mv_valid,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int SW = $clog2(SAMPLE_DIV + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int AW = 12 + AVG_LOG2;

  logic [SW-1:0]       scnt;
  logic                tick;
  logic [AVG_LOG2-1:0] ncnt;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic                batch_done;
  logic [11:0]         sample;
  logic [11:0]         avg;
  logic [21:0]         mv_prod;
  logic [9:0]          mv;
  state_t              state, state_nx;
  logic                bcd_start;
  logic                bcd_done;
  logic [11:0]         bcd;
  logic [RW-1:0]       rcnt;
  logic                rtick;
  logic [1:0]          idx;
  logic                live;
  logic [3:0]          nibble;

  assign sample     = 12'(s_in);
  assign tick       = (scnt == SW'(SAMPLE_DIV - 1));
  assign acc_sum    = acc + AW'(sample);
  assign batch_done = tick && (ncnt == '1);
  assign mv_prod    = 22'(avg) * 22'(SCALE_MV);
  assign mv         = 10'(mv_prod >> 12);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
      ncnt <= '0;
      acc  <= '0;
      avg  <= '0;
    end else begin
      scnt <= tick ? '0 : scnt + SW'(1);
      if (tick) begin
        if (batch_done) begin
          acc  <= '0;
          ncnt <= '0;
        end else begin
          acc  <= acc_sum;
          ncnt <= ncnt + AVG_LOG2'(1);
        end
      end
      // Batches finishing while a conversion is in flight are dropped.
      if (batch_done && state == IDLE) avg <= acc_sum[AW-1:AVG_LOG2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (batch_done) state_nx = MUL;
      MUL:     state_nx = BCD;
      BCD:     if (bcd_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_start = (state == MUL);
    mv_valid  = (state == DONE);
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bcd_start),
    .bin   (mv),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       mv_bcd <= '0;
    else if (state == BCD && bcd_done) mv_bcd <= {4'h0, bcd};
  end

  assign rtick  = (rcnt == RW'(REFRESH_DIV - 1));
  assign nibble = 4'(mv_bcd >> {idx, 2'b00});

  // The first refresh wrap only enables the display so the scan starts at digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= '0;
      live <= 1'b0;
    end else begin
      rcnt <= rtick ? '0 : rcnt + RW'(1);
      if (rtick) begin
        if (!live) live <= 1'b1;
        else       idx  <= idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'hF;
      seg <= BLANK_SEG;
      dp  <= 1'b1;
    end else if (live) begin
      an  <= ~(4'b0001 << idx);
      seg <= seg7(nibble);
      dp  <= (idx != 2'd3);
    end else begin
      an  <= 4'hF;
      seg <= BLANK_SEG;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_display.sv
// Scoreboard bench for adc_display with SAMPLE_DIV=4, AVG_LOG2=2, REFRESH_DIV=2.
module tb_adc_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_in = 16'h0000;
  logic [15:0] mv_bcd;
  logic        mv_valid;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  adc_display #(.SAMPLE_DIV(4), .AVG_LOG2(2), .REFRESH_DIV(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_in     (s_in),
    .mv_bcd   (mv_bcd),
    .mv_valid (mv_valid),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  // Cycles since reset release; pulse n of a constant stream lands at 28 + 16*n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mv_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid got bcd=%h at cyc %0d, expected no pulse", mv_bcd, cyc);
        end else begin
          e = q.pop_front();
          if (mv_bcd !== e.bcd || cyc != e.cyc) begin
            errors++;
            $display("FAIL valid_pulse got bcd=%h cyc=%0d, expected bcd=%h cyc=%0d",
                     mv_bcd, cyc, e.bcd, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_an"},       32'(an),       32'hF);
    chk({tag, "_seg"},      32'(seg),      32'h7F);
    chk({tag, "_dp"},       32'(dp),       32'h1);
    chk({tag, "_mv_bcd"},   32'(mv_bcd),   32'h0);
    chk({tag, "_mv_valid"}, 32'(mv_valid), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outs(tag);
    repeat (2) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [15:0] bcd, input int n);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.bcd = bcd;
      x.cyc = 28 + 16 * k;
      q.push_back(x);
    end
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 200 && cyc < c; i++) @(negedge clk);
    if (cyc < c) chk("run_to_timeout", 32'(cyc), 32'(c));
  endtask

  task automatic scan_check();
    logic [6:0] seg_exp [4];
    logic [3:0] pa;
    logic       found;
    seg_exp = '{7'h40, 7'h40, 7'h12, 7'h40};
    found = 1'b0;
    pa = an;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && pa != 4'b1110) found = 1'b1;
      pa = an;
    end
    chk("scan_start_found", 32'(found), 32'h1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("scan_an",  32'(an),  32'(~(4'b0001 << (i / 2)) & 4'hF));
      chk("scan_seg", 32'(seg), 32'(seg_exp[i / 2]));
      chk("scan_dp",  32'(dp),  (i / 2 == 3) ? 32'h0 : 32'h1);
    end
  endtask

  initial begin
    // Reset values, first refresh wrap, then constant mid-scale stream.
    s_in = 16'h0800;
    @(negedge clk);
    do_reset("reset");
    push(16'h0500, 3);
    @(negedge clk);
    chk("pre_refresh_an_e1", 32'(an), 32'hF);
    @(negedge clk);
    chk("pre_refresh_seg_e2", 32'(seg), 32'h7F);
    @(negedge clk);
    chk("first_digit_an",  32'(an),  32'hE);
    chk("first_digit_seg", 32'(seg), 32'h40);
    chk("first_digit_dp",  32'(dp),  32'h1);
    run_to(62);
    chk("midscale_drain", 32'(q.size()), 32'h0);

    s_in = 16'h0FFF;
    do_reset("rst_full");
    push(16'h0999, 2);
    run_to(46);
    chk("fullscale_drain", 32'(q.size()), 32'h0);

    do_reset("rst_alt");
    push(16'h0499, 2);
    repeat (6) begin
      s_in = 16'h0000;
      repeat (4) @(negedge clk);
      s_in = 16'h0FFF;
      repeat (4) @(negedge clk);
    end
    run_to(46);
    chk("alternating_drain", 32'(q.size()), 32'h0);

    s_in = 16'hF800;
    do_reset("rst_upper");
    push(16'h0500, 2);
    run_to(29);
    scan_check();
    run_to(46);
    chk("upper_bits_drain", 32'(q.size()), 32'h0);

    // Reset during the second conversion's BCD phase, then a fresh full-scale batch.
    s_in = 16'h0800;
    do_reset("rst_mid_pre");
    push(16'h0500, 1);
    run_to(38);
    chk("midconv_pre_drain", 32'(q.size()), 32'h0);
    chk("midconv_bcd_before", 32'(mv_bcd), 32'h0500);
    s_in = 16'h0FFF;
    do_reset("midconv");
    push(16'h0999, 1);
    run_to(34);
    chk("after_midconv_drain", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
